// File: rtl/dmem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_pkg : shared widths and FSM encoding for the line data memory
// Rev 1.0
// ------------------------------------------------------------------
package dmem_pkg;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;
endpackage
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_line_array : single-port synchronous 256-bit line store (read-first)
// Rev 1.0
// ------------------------------------------------------------------
module dmem_line_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] index,
   input  logic [LINE_W-1:0]     wdata,
   output logic [LINE_W-1:0]     rdata
);

   logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[index] <= wdata;
      end
      rdata <= mem[index];
   end

endmodule
`default_nettype wire

// File: rtl/dmem_line_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_line_ctrl : fixed-latency line read/write memory behind the dcache
// Optional access counters: define DMEM_ACCESS_COUNT_EN.   Rev 1.0
// ------------------------------------------------------------------
module dmem_line_ctrl
   import dmem_pkg::*;
#(
   parameter int LATENCY    = 10,
   parameter int DEPTH_LOG2 = 9,
   parameter int ADDR_LSB   = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic [LINE_W-1:0] data_o,
   output logic              ack_o
`ifdef DMEM_ACCESS_COUNT_EN
   ,
   output logic [31:0]       rd_cnt_o,
   output logic [31:0]       wr_cnt_o
`endif
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 2);

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [DEPTH_LOG2-1:0]   idx_q, arr_index;
   logic [LINE_W-1:0]       wdata_q, rdata;
   logic                    wr_q;
   logic                    capture, access, arr_we;
   logic                    unused_addr;

   assign unused_addr = ^{addr_i[ADDR_W-1:ADDR_LSB+DEPTH_LOG2], addr_i[ADDR_LSB-1:0]};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: begin
            if (enable_i) begin
               capture   = 1'b1;
               cnt_nxt   = LOAD_VAL;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               access    = 1'b1;
               state_nxt = ACK;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         ack_o  <= 1'b0;
         data_o <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ack_o <= access;
         if (access && !wr_q) begin
            data_o <= rdata;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (capture) begin
         idx_q   <= addr_i[ADDR_LSB +: DEPTH_LOG2];
         wdata_q <= data_i;
         wr_q    <= write_i;
      end
   end

   // Index straight from addr_i while idle so the registered read is ready by the access edge, even at LATENCY=2
   assign arr_index = (state == IDLE) ? addr_i[ADDR_LSB +: DEPTH_LOG2] : idx_q;
   assign arr_we    = access & wr_q & rst_i;

   dmem_line_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk_i),
      .we    (arr_we),
      .index (arr_index),
      .wdata (wdata_q),
      .rdata (rdata)
   );

`ifdef DMEM_ACCESS_COUNT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rd_cnt_o <= '0;
         wr_cnt_o <= '0;
      end else if (state == ACK) begin
         if (wr_q) begin
            if (wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + 1'b1;
         end else begin
            if (rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dmem_line_ctrl : directed bench with a timeline model of dmem_line_ctrl
// Rev 1.0
// ------------------------------------------------------------------
module tb_dmem_line_ctrl;
   localparam int LATENCY    = 10;
   localparam int DEPTH_LOG2 = 9;
   localparam int ADDR_LSB   = 5;

   logic         clk = 1'b0;
   logic         rst_i = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [255:0] data_i = '0;
   logic         enable_i = 1'b0;
   logic         write_i = 1'b0;
   logic [255:0] data_o;
   logic         ack_o;
`ifdef DMEM_ACCESS_COUNT_EN
   logic [31:0]  rd_cnt_o, wr_cnt_o;
`endif

   dmem_line_ctrl #(
      .LATENCY    (LATENCY),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .ADDR_LSB   (ADDR_LSB)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .data_o   (data_o),
      .ack_o    (ack_o)
`ifdef DMEM_ACCESS_COUNT_EN
      ,
      .rd_cnt_o (rd_cnt_o),
      .wr_cnt_o (wr_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Timeline model: a request is owned from its capture edge until LATENCY-1 edges later
   logic [255:0] mmem [int];
   int           cyc = 0;
   bit           m_init = 0, m_pend = 0, m_wr = 0;
   int           m_idx = 0, m_ack_at = 0, m_free_at = 0, m_cap_cyc = 0;
   logic [255:0] m_wd = '0;
   bit           e_ack = 0, e_known = 0;
   logic [255:0] e_data = '0;
   int           m_rd = 0, m_wrc = 0;

   always @(posedge clk) begin
      cyc++;
      e_ack = 0;
      if (!rst_i) begin
         m_init = 1; m_pend = 0; m_free_at = cyc + 1;
         e_data = '0; e_known = 1; m_rd = 0; m_wrc = 0;
      end else if (m_init) begin
         if (m_pend && cyc == m_ack_at) begin
            if (m_wr) begin
               mmem[m_idx] = m_wd;
               m_wrc++;
            end else begin
               m_rd++;
               if (mmem.exists(m_idx)) begin
                  e_data = mmem[m_idx]; e_known = 1;
               end else begin
                  e_known = 0;
               end
            end
            e_ack  = 1;
            m_pend = 0;
         end else if (!m_pend && cyc >= m_free_at && enable_i) begin
            m_pend    = 1;
            m_idx     = int'((addr_i >> ADDR_LSB) % (1 << DEPTH_LOG2));
            m_wd      = data_i;
            m_wr      = write_i;
            m_cap_cyc = cyc;
            m_ack_at  = cyc + LATENCY - 1;
            m_free_at = cyc + LATENCY + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("ack_o", {255'b0, ack_o}, {255'b0, e_ack});
         if (e_known) chk("data_o", data_o, e_data);
      end
   end

   int ack_cycles[$];
   int last_delay = -1;
   always @(negedge clk) begin
      if (ack_o === 1'b1) begin
         ack_cycles.push_back(cyc);
         last_delay = cyc - m_cap_cyc;
      end
   end

   task automatic wait_ack(input string name);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ack_o === 1'b1) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_timeout actual=no_ack expected=ack", name);
      end
   endtask

   task automatic do_req(input string name, input logic [31:0] a, input logic [255:0] d, input logic w);
      addr_i = a; data_i = d; write_i = w; enable_i = 1'b1;
      wait_ack(name);
      @(posedge clk); #2;
      enable_i = 1'b0;
   endtask

   logic [255:0] pat_p, pat_q, pat_r, pat_s, pat_t;
   int n_before;

   initial begin
      pat_p = {8{32'h1234_5678}};
      pat_q = {8{32'hA5A5_0F0F}};
      pat_r = {8{32'hDEAD_BEEF}};
      pat_s = {8{32'h0BAD_F00D}};
      pat_t = {8{32'hFFFF_0000}};

      // reset held for three edges
      repeat (3) @(posedge clk);
      #2;
      chk("reset_data_o", data_o, 256'h0);
      chk("reset_ack_o", {255'b0, ack_o}, 256'h0);
`ifdef DMEM_ACCESS_COUNT_EN
      chk("reset_rd_cnt", {224'b0, rd_cnt_o}, 256'd0);
      chk("reset_wr_cnt", {224'b0, wr_cnt_o}, 256'd0);
`endif
      rst_i = 1'b1;
      @(posedge clk); #2;

      // write then read line 0x21
      do_req("wr_420", 32'h0000_0420, pat_p, 1'b1);
      chk("wr_420_delay", 256'(last_delay), 256'd9);
      do_req("rd_420", 32'h0000_0420, '0, 1'b0);
      chk("rd_420_delay", 256'(last_delay), 256'd9);
      chk("rd_420_data", data_o, {8{32'h1234_5678}});

      // aliasing high bits and byte offset
      do_req("rd_4420", 32'h0000_4420, '0, 1'b0);
      chk("rd_4420_data", data_o, {8{32'h1234_5678}});
      do_req("rd_443f", 32'h0000_443F, '0, 1'b0);
      chk("rd_443f_data", data_o, {8{32'h1234_5678}});

      // inputs change and enable drops mid-write
      addr_i = 32'h0000_0840; data_i = pat_q; write_i = 1'b1; enable_i = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      addr_i = 32'h0000_0860; data_i = pat_r; write_i = 1'b0; enable_i = 1'b0;
      wait_ack("frozen_wr");
      chk("frozen_wr_delay", 256'(last_delay), 256'd9);
      @(posedge clk); #2;
      do_req("rd_840", 32'h0000_0840, '0, 1'b0);
      chk("rd_840_data", data_o, {8{32'hA5A5_0F0F}});

      // two back-to-back reads with enable held
      addr_i = 32'h0000_0420; write_i = 1'b0; enable_i = 1'b1;
      wait_ack("b2b_1");
      @(posedge clk); #2;
      addr_i = 32'h0000_0840;
      wait_ack("b2b_2");
      @(posedge clk); #2;
      enable_i = 1'b0;
      chk("b2b_spacing", 256'(ack_cycles[$] - ack_cycles[$-1]), 256'd11);
      chk("b2b_data", data_o, {8{32'hA5A5_0F0F}});

      // reset during a write to line 0x10 discards it
      do_req("wr_200", 32'h0000_0200, pat_s, 1'b1);
      n_before = ack_cycles.size();
      addr_i = 32'h0000_0200; data_i = pat_t; write_i = 1'b1; enable_i = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst_i = 1'b0; enable_i = 1'b0;
      @(posedge clk); #2;
      rst_i = 1'b1;
`ifdef DMEM_ACCESS_COUNT_EN
      chk("rst_rd_cnt", {224'b0, rd_cnt_o}, 256'd0);
      chk("rst_wr_cnt", {224'b0, wr_cnt_o}, 256'd0);
`endif
      repeat (15) @(posedge clk);
      #2;
      chk("abort_no_ack", 256'(ack_cycles.size()), 256'(n_before));
      do_req("rd_200", 32'h0000_0200, '0, 1'b0);
      chk("rd_200_data", data_o, {8{32'h0BAD_F00D}});

      // 3 writes + 1 more read since reset
      do_req("wr_1000", 32'h0000_1000, pat_p, 1'b1);
      do_req("wr_1020", 32'h0000_1020, pat_q, 1'b1);
      do_req("wr_1040", 32'h0000_1040, pat_r, 1'b1);
      do_req("rd_1020", 32'h0000_1020, '0, 1'b0);
      chk("rd_1020_data", data_o, {8{32'hA5A5_0F0F}});
      repeat (3) @(posedge clk);
      #2;
      chk("model_rd_count", 256'(m_rd), 256'd2);
      chk("model_wr_count", 256'(m_wrc), 256'd3);
`ifdef DMEM_ACCESS_COUNT_EN
      chk("rd_cnt", {224'b0, rd_cnt_o}, 256'd2);
      chk("wr_cnt", {224'b0, wr_cnt_o}, 256'd3);
      chk("rd_cnt_model", {224'b0, rd_cnt_o}, 256'(m_rd));
      chk("wr_cnt_model", {224'b0, wr_cnt_o}, 256'(m_wrc));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
